free_list: RTL and testbench

Physical-register free list for the 3-wide R10K rename stage. It supplies new destination PRs to the map table (`maptable_new_pr`) and takes back retired `Told` tags from the ROB. Storage is a circular FIFO of the 32 non-architectural PRs. An architectural head pointer, advanced at retirement, lets a branch-mispredict recovery (`BPRecoverEN`) restore the list in one cycle, in step with the map table's copy of `archi_maptable`.

---
 rtl/free_list.sv | 117 +++++++++++
 tb/tb_free_list.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list for a 3-wide rename stage.
// A circular FIFO holds the non-architectural physical registers. The
// speculative head hands out PRs to dispatch; the tail takes back retired
// Told tags; the architectural head follows retirement so a mispredict can
// rebuild the list in a single cycle.
//
// Handshake: dispatch_en is a per-way request and alloc_stall is the inverse
// of ready. A group of requests is accepted on a rising edge exactly when
// alloc_stall is low and BPRecoverEN is low. The group is all-or-nothing. The
// requester must hold dispatch_en while alloc_stall is high. retire_valid
// carries no back-pressure and is always accepted.
module free_list #(
  parameter int PR     = 6,
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           dispatch_en,
  output logic [2:0][PR-1:0]   free_pr,
  output logic [5:0]           free_count,
  output logic                 alloc_stall,
  input  logic [2:0]           retire_valid,
  input  logic [2:0][PR-1:0]   retire_told,
  input  logic                 BPRecoverEN
);

  localparam int DEPTH = NUM_PR - NUM_AR;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Storage and pointers (pointers carry one wrap bit above the index).
  logic [PR-1:0]    fl [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] arch_head;

  // Per-cycle derived values.
  logic [1:0]            alloc_cnt;
  logic [1:0]            retire_cnt;
  logic [2:0][1:0]       alloc_slot;
  logic [2:0][1:0]       retire_slot;
  logic [2:0][IDX_W-1:0] rd_idx;
  logic [2:0][IDX_W-1:0] wr_idx;
  logic [PTR_W-1:0]      count;

  // Number of set bits in a 3-bit way mask.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    popcount3 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  // Compact the requesting ways in age order (way 2 oldest).
  always_comb begin
    alloc_cnt      = popcount3(dispatch_en);
    retire_cnt     = popcount3(retire_valid);
    alloc_slot[2]  = 2'd0;
    alloc_slot[1]  = {1'b0, dispatch_en[2]};
    alloc_slot[0]  = {1'b0, dispatch_en[2]} + {1'b0, dispatch_en[1]};
    retire_slot[2] = 2'd0;
    retire_slot[1] = {1'b0, retire_valid[2]};
    retire_slot[0] = {1'b0, retire_valid[2]} + {1'b0, retire_valid[1]};
  end

  // FIFO read and write positions for each way, wrapping modulo DEPTH.
  always_comb begin
    for (int w = 0; w < 3; w++) begin
      rd_idx[w] = head[IDX_W-1:0] + IDX_W'(alloc_slot[w]);
      wr_idx[w] = tail[IDX_W-1:0] + IDX_W'(retire_slot[w]);
    end
  end

  // Occupancy and allocation outputs, from registered state only (no bypass).
  always_comb begin
    count       = tail - head;
    free_count  = 6'(count);
    alloc_stall = (count < PTR_W'(alloc_cnt));
    for (int w = 0; w < 3; w++) begin
      free_pr[w] = dispatch_en[w] ? fl[rd_idx[w]] : '0;
    end
  end

  // Pointer update: retirement always advances tail and arch_head; head either
  // snaps back to the committed point on recovery or advances by the accepted
  // allocation group.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= PTR_W'(DEPTH);
    end else begin
      tail      <= tail + PTR_W'(retire_cnt);
      arch_head <= arch_head + PTR_W'(retire_cnt);
      if (BPRecoverEN) begin
        head <= arch_head + PTR_W'(retire_cnt);
      end else if (!alloc_stall) begin
        head <= head + PTR_W'(alloc_cnt);
      end
    end
  end

  // Storage: reset loads the non-architectural PRs in order; retired Told
  // tags are written at the tail in compacted order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fl[i] <= PR'(NUM_AR + i);
      end
    end else begin
      for (int w = 0; w < 3; w++) begin
        if (retire_valid[w]) begin
          fl[wr_idx[w]] <= retire_told[w];
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, allocation, compaction, stall, free
// ordering across the wrap, recovery, simultaneous events and mid-run reset.
module tb_free_list;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      dispatch_en;
  logic [2:0][5:0] free_pr;
  logic [5:0]      free_count;
  logic            alloc_stall;
  logic [2:0]      retire_valid;
  logic [2:0][5:0] retire_told;
  logic            BPRecoverEN;

  int n_vec = 0;
  int n_err = 0;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_en  (dispatch_en),
    .free_pr      (free_pr),
    .free_count   (free_count),
    .alloc_stall  (alloc_stall),
    .retire_valid (retire_valid),
    .retire_told  (retire_told),
    .BPRecoverEN  (BPRecoverEN)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  function automatic int pop3(input logic [2:0] v);
    pop3 = int'(v[2]) + int'(v[1]) + int'(v[0]);
  endfunction

  // Protocol checks on the retire interface.
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      assert (int'(free_count) + pop3(retire_valid) <= 32)
        else $error("retire overflows free list");
      for (int w = 0; w < 3; w++) begin
        assert (!(retire_valid[w] && retire_told[w] == 6'd0))
          else $error("retire of PR 0 on way %0d", w);
      end
    end
  end

  // Advance one cycle; inputs and checks sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_en  = 3'b000;
    retire_valid = 3'b000;
    retire_told  = '0;
    BPRecoverEN  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (free_count !== 6'd32) begin
      $display("FAIL reset_count got %0d want 32", free_count); n_err++;
    end
    n_vec++;
    if (alloc_stall !== 1'b0) begin
      $display("FAIL reset_stall got %0b want 0", alloc_stall); n_err++;
    end
    n_vec++;
    if (free_pr !== 18'd0) begin
      $display("FAIL reset_idle_pr got %h want 0", free_pr); n_err++;
    end
  endtask

  task automatic test_full_alloc();
    apply_reset();
    dispatch_en = 3'b111;
    #1;
    n_vec++;
    if (free_pr !== {6'd32, 6'd33, 6'd34}) begin
      $display("FAIL full_alloc_pr got %h want %h", free_pr, {6'd32, 6'd33, 6'd34}); n_err++;
    end
    n_vec++;
    if (alloc_stall !== 1'b0) begin
      $display("FAIL full_alloc_stall got %0b want 0", alloc_stall); n_err++;
    end
    tick();
    dispatch_en = 3'b000;
    #1;
    n_vec++;
    if (free_count !== 6'd29) begin
      $display("FAIL full_alloc_count got %0d want 29", free_count); n_err++;
    end
  endtask

  task automatic test_compaction();
    apply_reset();
    dispatch_en = 3'b101;
    #1;
    n_vec++;
    if (free_pr !== {6'd32, 6'd0, 6'd33}) begin
      $display("FAIL compaction_pr got %h want %h", free_pr, {6'd32, 6'd0, 6'd33}); n_err++;
    end
    tick();
    dispatch_en = 3'b000;
    #1;
    n_vec++;
    if (free_count !== 6'd30) begin
      $display("FAIL compaction_count got %0d want 30", free_count); n_err++;
    end
  endtask

  task automatic test_stall_and_free();
    logic [5:0] e;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      dispatch_en = 3'b111;
      #1;
      e = 6'(32 + 3 * c);
      n_vec++;
      if (free_pr[2] !== e) begin
        $display("FAIL stall_fill_pr cycle %0d got %0d want %0d", c, free_pr[2], e); n_err++;
      end
      tick();
    end
    // Two requests exactly fit the two remaining entries.
    dispatch_en = 3'b011;
    #1;
    n_vec++;
    if (alloc_stall !== 1'b0) begin
      $display("FAIL stall_boundary got %0b want 0", alloc_stall); n_err++;
    end
    dispatch_en = 3'b111;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (alloc_stall !== 1'b1) begin
        $display("FAIL stall_flag cycle %0d got %0b want 1", c, alloc_stall); n_err++;
      end
      n_vec++;
      if (free_count !== 6'd2) begin
        $display("FAIL stall_count cycle %0d got %0d want 2", c, free_count); n_err++;
      end
      tick();
    end
    // Free two tags on ways 2 and 1.
    dispatch_en  = 3'b000;
    retire_valid = 3'b110;
    retire_told  = {6'd5, 6'd7, 6'd0};
    tick();
    retire_valid = 3'b000;
    retire_told  = '0;
    #1;
    n_vec++;
    if (free_count !== 6'd4) begin
      $display("FAIL free_count got %0d want 4", free_count); n_err++;
    end
    dispatch_en = 3'b111;
    #1;
    n_vec++;
    if (free_pr !== {6'd62, 6'd63, 6'd5}) begin
      $display("FAIL free_order_a got %h want %h", free_pr, {6'd62, 6'd63, 6'd5}); n_err++;
    end
    tick();
    dispatch_en = 3'b100;
    #1;
    n_vec++;
    if (free_pr !== {6'd7, 6'd0, 6'd0}) begin
      $display("FAIL free_order_b got %h want %h", free_pr, {6'd7, 6'd0, 6'd0}); n_err++;
    end
    tick();
    dispatch_en = 3'b001;
    #1;
    n_vec++;
    if (free_count !== 6'd0) begin
      $display("FAIL empty_count got %0d want 0", free_count); n_err++;
    end
    n_vec++;
    if (alloc_stall !== 1'b1) begin
      $display("FAIL empty_stall got %0b want 1", alloc_stall); n_err++;
    end
    dispatch_en = 3'b000;
  endtask

  task automatic test_recovery();
    apply_reset();
    dispatch_en = 3'b111;
    tick();
    tick();
    n_vec++;
    if (free_count !== 6'd26) begin
      $display("FAIL recover_pre_count got %0d want 26", free_count); n_err++;
    end
    // Recovery with two retirements and a dispatch that must be dropped.
    retire_valid = 3'b110;
    retire_told  = {6'd1, 6'd2, 6'd0};
    BPRecoverEN  = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (free_count !== 6'd32) begin
      $display("FAIL recover_count got %0d want 32", free_count); n_err++;
    end
    dispatch_en = 3'b111;
    #1;
    n_vec++;
    if (free_pr !== {6'd34, 6'd35, 6'd36}) begin
      $display("FAIL recover_pr got %h want %h", free_pr, {6'd34, 6'd35, 6'd36}); n_err++;
    end
    tick();
    dispatch_en = 3'b000;
    #1;
    n_vec++;
    if (free_count !== 6'd29) begin
      $display("FAIL recover_resume_count got %0d want 29", free_count); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    dispatch_en = 3'b111;
    tick();
    // Allocate three and free three in the same cycle.
    retire_valid = 3'b111;
    retire_told  = {6'd10, 6'd11, 6'd12};
    #1;
    n_vec++;
    if (free_pr !== {6'd35, 6'd36, 6'd37}) begin
      $display("FAIL b2b_pr got %h want %h", free_pr, {6'd35, 6'd36, 6'd37}); n_err++;
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (free_count !== 6'd29) begin
      $display("FAIL b2b_count got %0d want 29", free_count); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    // Continues from the non-reset state left by the previous test.
    reset        = 1'b0;
    dispatch_en  = 3'b111;
    retire_valid = 3'b111;
    retire_told  = {6'd20, 6'd21, 6'd22};
    tick();
    reset        = 1'b1;
    retire_valid = 3'b000;
    retire_told  = '0;
    #1;
    n_vec++;
    if (free_count !== 6'd32) begin
      $display("FAIL mid_reset_count got %0d want 32", free_count); n_err++;
    end
    n_vec++;
    if (free_pr[2] !== 6'd32) begin
      $display("FAIL mid_reset_pr got %0d want 32", free_pr[2]); n_err++;
    end
    dispatch_en = 3'b000;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_full_alloc();
    test_compaction();
    test_stall_and_free();
    test_recovery();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
